// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit result FIFOs drained one entry per cycle
// onto a registered broadcast bus using round-robin selection.
module cdb_arbiter #(
  parameter int NREQ      = 3,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*TAG_W-1:0]  req_tag,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   flush,
  input  logic                   cdb_hold,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [1:0]             cdb_src
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = TAG_W + DATA_W;

  logic [EW-1:0]   mem    [NREQ][BUF_DEPTH];
  logic [PW-1:0]   wr_ptr [NREQ];
  logic [PW-1:0]   rd_ptr [NREQ];
  logic [CW-1:0]   count  [NREQ];
  logic [1:0]      rr_ptr;
  logic [1:0]      winner;
  logic            found;
  logic            pop;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop_sel;
  int unsigned     idx;

  // Ready comes from the count register alone, so a full FIFO stays not-ready
  // even in a cycle where it is being popped.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (count[i] != CW'(BUF_DEPTH));
    end
  end

  assign push = req_valid & req_ready & {NREQ{~flush}};

  // Round-robin search over non-empty FIFOs starting at rr_ptr; pushes of the
  // current cycle are not visible here, so there is no bypass.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && count[idx[1:0]] != '0) begin
        found  = 1'b1;
        winner = idx[1:0];
      end
    end
  end

  assign pop     = found & ~cdb_hold & ~flush;
  assign pop_sel = pop ? (NREQ'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= pop;
      if (pop) begin
        {cdb_tag, cdb_data} <= mem[winner][rd_ptr[winner]];
        cdb_src             <= winner;
        rr_ptr              <= (winner == 2'(NREQ - 1)) ? '0 : winner + 2'd1;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (flush) begin
          count[i]  <= '0;
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (push[i])    wr_ptr[i] <= wr_ptr[i] + PW'(1);
          if (pop_sel[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
          count[i] <= count[i] + CW'(push[i]) - CW'(pop_sel[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a random soak, all checked
// against a queue-based reference model of the arbiter.
module tb_cdb_arbiter;

  localparam int NREQ  = 3;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_tag;
  logic [95:0] req_data;
  logic        flush;
  logic        cdb_hold;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NREQ(NREQ), .TAG_W(4), .DATA_W(32), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data), .flush(flush), .cdb_hold(cdb_hold),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue per unit, rr index, expected bus registers
  logic [35:0] q [NREQ][$];
  int          rr;
  logic        m_v;
  logic [3:0]  m_tag;
  logic [31:0] m_data;
  logic [1:0]  m_src;
  logic [5:0]  seen [$];
  int          wait_n [NREQ];
  int          max_wait;

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    for (int i = 0; i < NREQ; i++) r[i] = (q[i].size() != DEPTH);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) begin
      q[i].delete();
      wait_n[i] = 0;
    end
    rr = 0; m_v = 1'b0; m_tag = '0; m_data = '0; m_src = '0;
  endtask

  task automatic step(input logic [2:0] v, input logic [11:0] tg, input logic [95:0] dt,
                      input logic fl, input logic hd);
    logic [2:0]  rdy;
    logic [2:0]  pend;
    logic [35:0] e;
    int          w;
    req_valid = v; req_tag = tg; req_data = dt; flush = fl; cdb_hold = hd;
    rdy = m_ready();
    for (int i = 0; i < NREQ; i++) pend[i] = (q[i].size() > 0);
    if (fl) begin
      for (int i = 0; i < NREQ; i++) q[i].delete();
      m_v = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && q[(rr + k) % NREQ].size() > 0) w = (rr + k) % NREQ;
      end
      if (!hd && w >= 0) begin
        e = q[w].pop_front();
        m_v = 1'b1; m_tag = e[35:32]; m_data = e[31:0]; m_src = 2'(w);
        rr = (w + 1) % NREQ;
      end else begin
        m_v = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && rdy[i]) q[i].push_back({tg[i*4 +: 4], dt[i*32 +: 32]});
      end
    end
    @(posedge clk);
    #1;
    check("bus", {cdb_valid, cdb_tag, cdb_data, cdb_src, req_ready},
                 {m_v, m_tag, m_data, m_src, m_ready()});
    if (cdb_valid) seen.push_back({cdb_src, cdb_tag});
    if (fl) begin
      for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
    end else if (cdb_valid) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] || cdb_src == 2'(i)) wait_n[i] = 0;
        else begin
          wait_n[i]++;
          if (wait_n[i] > max_wait) max_wait = wait_n[i];
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0; req_tag = '0; req_data = '0; flush = 1'b0; cdb_hold = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_order(input string tag, input logic [5:0] a, input logic [5:0] b,
                             input logic [5:0] c);
    check({tag, "_n"}, 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      check({tag, "_0"}, 64'(seen[0]), 64'(a));
      check({tag, "_1"}, 64'(seen[1]), 64'(b));
      check({tag, "_2"}, 64'(seen[2]), 64'(c));
    end
  endtask

  initial begin
    max_wait = 0;
    do_reset();
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_tag",   64'(cdb_tag),   64'd0);
    check("rst_data",  64'(cdb_data),  64'd0);
    check("rst_src",   64'(cdb_src),   64'd0);
    check("rst_ready", 64'(req_ready), 64'h7);

    // single result, two-cycle latency
    step(3'b001, 12'h003, 96'h11, 1'b0, 1'b0);
    check("single_e1_valid", 64'(cdb_valid), 64'd0);
    idle(1);
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_tag",   64'(cdb_tag),   64'd3);
    check("single_data",  64'(cdb_data),  64'h11);
    check("single_src",   64'(cdb_src),   64'd0);
    idle(1);
    check("single_drop", 64'(cdb_valid), 64'd0);

    // three-way contention from rr=0, then from rr=2
    do_reset();
    seen.delete();
    step(3'b111, {4'd3, 4'd2, 4'd1}, rnd96(), 1'b0, 1'b0);
    idle(4);
    check_order("rr0", {2'd0, 4'd1}, {2'd1, 4'd2}, {2'd2, 4'd3});
    step(3'b010, {4'd0, 4'd8, 4'd0}, rnd96(), 1'b0, 1'b0);
    idle(2);
    seen.delete();
    step(3'b111, {4'd3, 4'd2, 4'd1}, rnd96(), 1'b0, 1'b0);
    idle(4);
    check_order("rr2", {2'd2, 4'd3}, {2'd0, 4'd1}, {2'd1, 4'd2});

    // back-pressure on LSU
    seen.delete();
    step(3'b010, {4'd0, 4'd5, 4'd0}, rnd96(), 1'b0, 1'b1);
    step(3'b010, {4'd0, 4'd6, 4'd0}, rnd96(), 1'b0, 1'b1);
    check("bp_full", 64'(req_ready[1]), 64'd0);
    step(3'b010, {4'd0, 4'd7, 4'd0}, rnd96(), 1'b0, 1'b1);
    check("bp_held_valid", 64'(cdb_valid), 64'd0);
    step(3'b010, {4'd0, 4'd7, 4'd0}, rnd96(), 1'b0, 1'b0);
    check("bp_ready_back", 64'(req_ready[1]), 64'd1);
    step(3'b010, {4'd0, 4'd7, 4'd0}, rnd96(), 1'b0, 1'b0);
    idle(3);
    check_order("bp", {2'd1, 4'd5}, {2'd1, 4'd6}, {2'd1, 4'd7});

    // flush with a colliding push; rr (2) must survive
    step(3'b101, {4'd9, 4'd0, 4'd4}, rnd96(), 1'b0, 1'b1);
    step(3'b001, {4'd0, 4'd0, 4'd10}, rnd96(), 1'b1, 1'b0);
    check("flush_valid", 64'(cdb_valid), 64'd0);
    check("flush_ready", 64'(req_ready), 64'h7);
    seen.delete();
    idle(3);
    check("flush_quiet", 64'(seen.size()), 64'd0);
    step(3'b111, {4'd3, 4'd2, 4'd1}, rnd96(), 1'b0, 1'b0);
    idle(4);
    check_order("flush_rr", {2'd2, 4'd3}, {2'd0, 4'd1}, {2'd1, 4'd2});

    // asynchronous reset while broadcasting with entries still buffered
    step(3'b111, {4'd3, 4'd2, 4'd1}, rnd96(), 1'b0, 1'b0);
    idle(1);
    check("prerst_valid", 64'(cdb_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(cdb_valid), 64'd0);
    check("arst_ready", 64'(req_ready), 64'h7);
    check("arst_tag",   64'(cdb_tag),   64'd0);
    model_clear();
    #1 rst = 1'b1;
    seen.delete();
    idle(4);
    check("arst_quiet", 64'(seen.size()), 64'd0);

    // random soak
    max_wait = 0;
    for (int n = 0; n < 10000; n++) begin
      step(3'($urandom_range(0, 7)), 12'($urandom()), rnd96(),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(8);
    check("fair_max_wait", 64'(max_wait <= NREQ - 1), 64'd1);
    check("drain_ready", 64'(req_ready), 64'h7);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus arbiter for the out-of-order core.
- Collects completion results (rb tag + value) from the functional units (ALU, AGU/load path, branch resolve) and serialises them onto a single registered CDB. The reorder buffer and reservation stations snoop this bus.
- Each requester has a small FIFO, so a unit never stalls unless its FIFO is full.
- Grants are round-robin, one broadcast per cycle, and all buffered results are flushed on mispredict.

Parameters:
- NREQ, 3, number of requesting functional units (index 0=ALU, 1=LSU, 2=BRANCH).
- TAG_W, 4, reorder-buffer tag width.
- DATA_W, 32, result width.
- BUF_DEPTH, 2, per-requester FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-unit result valid.
- req_ready  out  NREQ  per-unit FIFO not full.
- req_tag  in  NREQ*TAG_W  per-unit rb tag; unit i at bits [i*TAG_W +: TAG_W].
- req_data  in  NREQ*DATA_W  per-unit result; unit i at bits [i*DATA_W +: DATA_W].
- flush  in  1  mispredict flush; discards all buffered results.
- cdb_hold  in  1  consumer back-pressure; no broadcast while high.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast rb tag (registered).
- cdb_data  out  DATA_W  broadcast value (registered).
- cdb_src  out  2  index of the winning requester (registered).

Behaviour:
- Reset (rst low, async):
  - all FIFOs empty, all counts 0, rr_ptr=0;
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0;
  - req_ready = all ones once counts are 0.
- req_ready[i] = (count[i] != BUF_DEPTH).
  - Decoded from the count register only; there is no combinational path from pop or cdb_hold to ready.
  - A full FIFO being popped in the same cycle still shows ready=0.
- Push: req_valid[i] & req_ready[i] at a rising edge writes {tag,data} at wr_ptr[i]; wr_ptr wraps modulo BUF_DEPTH.
  - req_valid while not ready is ignored (the requester holds it).
- Arbitration (combinational, every cycle):
  - candidates are the FIFOs with count != 0;
  - search starts at rr_ptr and wraps upward; the first non-empty FIFO wins.
  - If cdb_hold=0, flush=0 and a winner exists:
    - pop the winner's head at the edge;
    - next edge: cdb_valid=1, cdb_tag/cdb_data = popped entry, cdb_src = winner;
    - rr_ptr = (winner+1) mod NREQ.
  - Otherwise cdb_valid goes to 0 at the next edge; tag/data/src keep their last values and rr_ptr is unchanged.
- Latency: a result pushed at edge N into an empty FIFO with no contention is popped at edge N+1. cdb_valid is high for exactly one cycle, starting after edge N+1 (2 cycles total).
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
  - Push to an empty FIFO is not bypassed; the entry is eligible only from the next cycle.
- Flush (synchronous, highest priority):
  - at the edge, all counts and pointers clear to 0;
  - pushes presented in the flush cycle are dropped;
  - no pop occurs and cdb_valid goes to 0 next edge;
  - rr_ptr is retained.
- cdb_hold and flush together: flush behaviour applies.
- Ordering: entries from a single requester broadcast in FIFO order. There is no ordering guarantee across requesters.
- Fairness: with all NREQ FIFOs continuously non-empty and no hold, each requester wins exactly once every NREQ cycles.
- Tag/data widths pass through unmodified; no arithmetic apart from pointer and count wrap.
- Reset asserted mid-operation clears all state immediately, including an in-flight cdb_valid.

Test Plan:
- Single result: reset, push ALU tag=3 data=0x11 at edge 1 → cdb_valid high only in the cycle after edge 2, tag=3, data=0x11, src=0, rr_ptr=1.
- Three-way contention: all units push in the same cycle (tags 1, 2, 3), rr_ptr=0 → broadcasts on three consecutive cycles, src order 0, 1, 2. Repeating with rr_ptr=2 → order 2, 0, 1.
- Back-pressure: cdb_hold=1 while LSU pushes tags 5, 6, 7 → ready drops to 0 after two accepts and tag 7 is held. Releasing hold → broadcasts 5, then 6, then 7, with ready returning as space frees.
- Flush: buffer tags 4 (ALU) and 9 (BRANCH), assert flush for one cycle together with a new push of tag 10 → no broadcast follows, all req_ready=1, rr_ptr unchanged.
- Reset mid-broadcast: drop rst while cdb_valid=1 with entries still buffered → cdb_valid=0 immediately; after release, no broadcast occurs without new pushes.
- Fairness soak: random valid on all units with random hold for 10k cycles → a scoreboard checks per-unit FIFO ordering, no loss or duplication, and at most NREQ-1 grants to other units between two grants of a continuously pending unit (hold cycles excluded).
